// File: rtl/sysa_param.sv
// Weight-stationary N x N systolic array: skewed row inputs, per-PE multiply-accumulate
// flowing down each column, deskewed column outputs with a matching valid pipe.
//
// state | meaning
// NOWGT | no weights loaded yet; inputs refused until the first w_load
// RUN   | weights stable, vectors accepted one per enabled cycle
// DRAIN | reload pending; wait for in-flight vectors to finish, then capture w
module sysa_param #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                w_load,
    input  logic [DW*N*N-1:0]   w,
    input  logic                in_valid,
    input  logic [DW*N-1:0]     in,
    output logic                in_ready,
    output logic                out_valid,
    output logic [AW*N-1:0]     out,
    output logic                busy
);

    localparam int VP = 2*N-1;

    typedef enum logic [1:0] {NOWGT, RUN, DRAIN} state_t;

    state_t             state_q;
    logic               accept;
    logic               capture;
    logic [VP-1:0]      vpipe_q, vpipe_d;
    logic               out_valid_q, out_valid_d;
    logic [AW*N-1:0]    out_q, out_d;
    logic [DW*N-1:0]    in_gated;

    logic signed [DW-1:0] row_in  [N];
    logic signed [DW-1:0] h_out   [N][N-1];
    logic signed [AW-1:0] v_out   [N][N];
    logic signed [AW-1:0] aligned [N];

    assign busy      = |vpipe_q;
    assign in_ready  = en && (state_q == RUN);
    assign accept    = in_ready && in_valid;
    // NOWGT loads on request; DRAIN loads only once nothing is left in flight
    assign capture   = en && (((state_q == NOWGT) && w_load) ||
                              ((state_q == DRAIN) && !busy));
    assign in_gated  = accept ? in : '0;
    assign out_valid = out_valid_q;
    assign out       = out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NOWGT;
        end else if (en) begin
            case (state_q)
                NOWGT:   if (w_load) state_q <= RUN;
                RUN:     if (w_load) state_q <= DRAIN;
                DRAIN:   if (!busy)  state_q <= RUN;
                default: state_q <= NOWGT;
            endcase
        end
    end

    always_comb begin
        vpipe_d = vpipe_q;
        if (en) vpipe_d = {vpipe_q[VP-2:0], accept};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vpipe_q <= '0;
        else      vpipe_q <= vpipe_d;
    end

    for (genvar r = 0; r < N; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign row_in[r] = in_gated[DW-1:0];
        end else begin : g_dly
            logic [DW-1:0] sk_q [r];
            logic [DW-1:0] sk_d [r];

            always_comb begin
                sk_d = sk_q;
                if (en) begin
                    sk_d[0] = in_gated[DW*r +: DW];
                    for (int k = 1; k < r; k++) sk_d[k] = sk_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < r; k++) sk_q[k] <= '0;
                end else begin
                    sk_q <= sk_d;
                end
            end

            assign row_in[r] = sk_q[r-1];
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_pe
            logic signed [DW-1:0] left;
            logic signed [DW-1:0] w_q, w_d;
            logic signed [AW-1:0] up, prod;
            logic signed [AW-1:0] v_q, v_d;

            if (c == 0) begin : g_l0
                assign left = row_in[r];
            end else begin : g_ln
                assign left = h_out[r][c-1];
            end

            if (r == 0) begin : g_u0
                assign up = '0;
            end else begin : g_un
                assign up = v_out[r-1][c];
            end

            // both operands sign-extended to AW, so the product is exact before wrapping
            assign prod = AW'(left) * AW'(w_q);

            always_comb begin
                w_d = w_q;
                v_d = v_q;
                if (capture) w_d = w[DW*(r*N+c) +: DW];
                if (en)      v_d = up + prod;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    w_q <= '0;
                    v_q <= '0;
                end else begin
                    w_q <= w_d;
                    v_q <= v_d;
                end
            end

            assign v_out[r][c] = v_q;

            if (c < N-1) begin : g_h
                logic signed [DW-1:0] h_q, h_d;

                always_comb h_d = en ? left : h_q;

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) h_q <= '0;
                    else      h_q <= h_d;
                end

                assign h_out[r][c] = h_q;
            end
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_deskew
        if (c == N-1) begin : g_pass
            assign aligned[c] = v_out[N-1][c];
        end else begin : g_dly
            localparam int D = N-1-c;
            logic [AW-1:0] ds_q [D];
            logic [AW-1:0] ds_d [D];

            always_comb begin
                ds_d = ds_q;
                if (en) begin
                    ds_d[0] = v_out[N-1][c];
                    for (int k = 1; k < D; k++) ds_d[k] = ds_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < D; k++) ds_q[k] <= '0;
                end else begin
                    ds_q <= ds_d;
                end
            end

            assign aligned[c] = ds_q[D-1];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (en) begin
            out_valid_d = vpipe_q[VP-1];
            if (vpipe_q[VP-1]) begin
                for (int c = 0; c < N; c++) out_d[AW*c +: AW] = aligned[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_sysa_param.sv
// Randomized and directed bench for sysa_param against a matrix-vector reference model
// that tracks accepted vectors by enabled-cycle due time.
module tb_sysa_param;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               w_load = 1'b0;
    logic               in_valid = 1'b0;
    logic [DW*N*N-1:0]  w = '0;
    logic [DW*N-1:0]    in_v = '0;
    logic               in_ready, out_valid, busy;
    logic [AW*N-1:0]    out_v;

    always #5 clk = ~clk;

    sysa_param #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .w_load(w_load), .w(w),
        .in_valid(in_valid), .in(in_v), .in_ready(in_ready),
        .out_valid(out_valid), .out(out_v), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        logic [63:0] res;
    } pend_t;

    localparam int M_NOWGT = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    pend_t       pend[$];
    int          m_mode;
    int          wm [N][N];
    int          e_cnt = 0;
    logic        exp_ov;
    logic [63:0] exp_out;
    int          ov_seen;

    function automatic logic [63:0] matvec(input logic [DW*N-1:0] v);
        logic [63:0] res = '0;
        for (int c = 0; c < N; c++) begin
            int s = 0;
            for (int r = 0; r < N; r++) s += int'($signed(v[DW*r +: DW])) * wm[r][c];
            res[AW*c +: AW] = s[AW-1:0];
        end
        return res;
    endfunction

    task automatic load_w();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                wm[r][c] = int'($signed(w[DW*(r*N+c) +: DW]));
    endtask

    task automatic model_reset();
        pend.delete();
        m_mode  = M_NOWGT;
        exp_ov  = 1'b0;
        exp_out = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; w_load = 1'b0; in_valid = 1'b0;
        model_reset();
        #1;
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_out", out_v, '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic cycle(input logic e, input logic wl, input logic iv, input logic [DW*N-1:0] data);
        logic  exp_rdy;
        logic  was_idle;
        pend_t p;
        @(negedge clk);
        en = e; w_load = wl; in_valid = iv; in_v = data;
        #1;
        exp_rdy  = e && (m_mode == M_RUN);
        was_idle = (pend.size() == 0);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("busy", busy, !was_idle);
        if (e) begin
            e_cnt++;
            if (exp_rdy && iv) begin
                p.due = e_cnt + 2*N - 1;
                p.res = matvec(data);
                pend.push_back(p);
            end
            case (m_mode)
                M_NOWGT: if (wl) begin load_w(); m_mode = M_RUN; end
                M_RUN:   if (wl) m_mode = M_DRAIN;
                default: if (was_idle) begin load_w(); m_mode = M_RUN; end
            endcase
            exp_ov = 1'b0;
            if (pend.size() > 0 && pend[0].due == e_cnt) begin
                exp_ov  = 1'b1;
                exp_out = pend[0].res;
                void'(pend.pop_front());
            end
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", out_valid, exp_ov);
        check_eq("out", out_v, exp_out);
        if (out_valid) ov_seen++;
    endtask

    function automatic logic [DW*N-1:0] rnd_vec();
        return DW*N'($urandom);
    endfunction

    function automatic logic [DW*N*N-1:0] rnd_w();
        logic [DW*N*N-1:0] v;
        for (int k = 0; k < DW*N*N/32; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        int first;
        model_reset();
        do_reset();

        // no weights yet: a valid input must be refused
        cycle(1'b1, 1'b0, 1'b1, 32'h04030201);

        // identity weights, single vector, latency 2N-1
        w = '0;
        for (int r = 0; r < N; r++) w[DW*(r*N+r) +: DW] = 8'd1;
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, 32'h04030201);
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, 1'b0, 1'b0, '0);
            if (out_valid && first < 0) first = k;
        end
        check_eq("identity_latency", first, 2*N-1);
        check_eq("identity_out", out_v, 64'h0004_0003_0002_0001);

        // w(r,c)=r+c, eight back-to-back vectors
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) w[DW*(r*N+c) +: DW] = DW'(r+c);
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        ov_seen = 0;
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 1'b1, rnd_vec());
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b0, '0);
        check_eq("b2b_count", ov_seen, 8);

        // wrap checks
        w = {(N*N){8'h80}};
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, {N{8'h80}});
        for (int k = 0; k < 9; k++) cycle(1'b1, 1'b0, 1'b0, '0);
        check_eq("wrap_min", out_v, 64'h0);
        w = {(N*N){8'h7f}};
        cycle(1'b1, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b1, {N{8'h80}});
        for (int k = 0; k < 9; k++) cycle(1'b1, 1'b0, 1'b0, '0);
        check_eq("wrap_mix", out_v, 64'h0200_0200_0200_0200);

        // reload with three vectors in flight
        w = rnd_w();
        cycle(1'b1, 1'b0, 1'b1, rnd_vec());
        cycle(1'b1, 1'b0, 1'b1, rnd_vec());
        w = rnd_w();
        cycle(1'b1, 1'b1, 1'b1, rnd_vec());
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b1, rnd_vec());
        for (int k = 0; k < 9; k++) cycle(1'b1, 1'b0, 1'b0, '0);

        // enable stall mid-stream; ignored requests while frozen
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1, rnd_vec());
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, rnd_vec());
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b0, '0);

        // reset with four vectors in flight
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1, rnd_vec());
        do_reset();
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 1'b1, rnd_vec());

        // random traffic
        w = rnd_w();
        cycle(1'b1, 1'b1, 1'b0, '0);
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0) w = rnd_w();
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) != 0, rnd_vec());
        end
        for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sysa_param.md
SYSA_PARAM -- requirements
Module: sysa_param

Interface
REQ-001 Parameter N, default 4: array dimension (N x N processing elements); legal range 2..8.
REQ-002 Parameter DW, default 8: width of each input and weight element.
REQ-003 Parameter AW, default 16: width of each partial sum and output element; AW >= 2*DW.
REQ-004 clk  in  1: single clock; all state updates on its rising edge.
REQ-005 rst  in  1: asynchronous, active-low reset.
REQ-006 en  in  1: global advance enable; 0 = freeze all state, including the FSM, skew lines and valid pipe.
REQ-007 w_load  in  1: weight-load request, sampled when en=1.
REQ-008 w  in  DW*N*N: weight matrix; element (r,c) occupies bits [DW*(r*N+c) +: DW].
REQ-009 in_valid  in  1: input vector valid.
REQ-010 in  in  DW*N: input vector; row r occupies bits [DW*r +: DW].
REQ-011 in_ready  out  1: vector accepted this cycle when in_valid=1, in_ready=1 and en=1.
REQ-012 out_valid  out  1: out holds an aligned result vector.
REQ-013 out  out  AW*N: result vector; column c occupies bits [AW*c +: AW].
REQ-014 busy  out  1: high while any accepted vector is still in flight.

Function
REQ-015 All arithmetic SHALL be two's-complement signed.
  - Products: DW x DW, sign-extended to AW.
  - Sums: wrap modulo 2^AW, with no saturation.
REQ-016 Each PE(r,c) SHALL hold a stationary weight register.
  - Each enabled cycle it SHALL register right = left.
  - Each enabled cycle it SHALL register down = up + left*w(r,c).
  - The up input of row 0 is 0.
REQ-017 An input skew stage SHALL delay row r by r cycles before it enters PE(r,0).
REQ-018 A lane not carrying an accepted vector SHALL inject 0.
REQ-019 An output deskew stage SHALL delay column c by N-1-c cycles, so that all columns of one vector appear together.
REQ-020 For a vector accepted at enabled cycle t:
  - out SHALL present out[c] = sum over r of in[r]*w(r,c) at enabled cycle t+2N-1.
  - out_valid=1 for exactly that cycle.
REQ-021 Latency SHALL count enabled cycles only; cycles with en=0 SHALL NOT advance it.
REQ-022 Back-to-back accepts SHALL be supported, giving throughput of one vector per enabled cycle.
REQ-023 A 2N-1 stage valid pipe SHALL track accepted vectors; busy = OR of all stages.
REQ-024 The FSM SHALL have states NOWGT, RUN and DRAIN.
REQ-025 NOWGT: in_ready=0. On w_load=1, capture w into all weight registers and go to RUN.
REQ-026 RUN: in_ready=1. On w_load=1, go to DRAIN; that cycle's in_ready stays 1, so a simultaneous valid input IS accepted with the old weights.
REQ-027 DRAIN: in_ready=0. When the valid pipe is empty (busy=0), capture w and return to RUN in the same cycle.
REQ-028 In DRAIN, the weights captured SHALL be those present on w in the capture cycle; the w_load level SHALL be ignored.
REQ-029 Weights SHALL change only at a capture event; vectors in flight SHALL always complete with the weights they entered with.
REQ-030 out SHALL hold its last value when out_valid=0.
REQ-031 With en=0:
  - in_ready SHALL read 0.
  - in_valid and w_load SHALL be ignored.
  - out and out_valid SHALL hold.

Reset
REQ-032 While rst=0:
  - FSM = NOWGT.
  - All weight, PE, skew, deskew and valid registers = 0.
  - out=0, out_valid=0, in_ready=0, busy=0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight vectors; no out_valid SHALL appear for them after release.
REQ-034 After rst rises, the block SHALL require a w_load before accepting data.

Verification
REQ-035 N=3, DW=8, AW=16, with w = identity and in = (1,2,3) accepted at cycle t -> out=(1,2,3) with out_valid at t+5 only.
REQ-036 N=4, with w(r,c) = r+c and 8 back-to-back random vectors -> 8 consecutive out_valid cycles, each matching the reference matrix product.
REQ-037 w=all -128 (0x80), in=all -128, N=4 -> each out element = 4*16384 = 65536 mod 2^16 = 0x0000 (wrap check); with w=all 127, in=all -128 -> 4*(-16256) = -65024 mod 2^16 = 0x0200.
REQ-038 In RUN with 3 vectors in flight, assert w_load with new w:
  - in_ready drops the next cycle.
  - The old-weight results emerge.
  - busy falls and the new weights are captured.
  - in_ready returns; the next vector uses the new weights.
REQ-039 Toggle en=0 for 3 cycles mid-stream -> out_valid is delayed by exactly 3 cycles and the results are unchanged.
REQ-040 Assert rst low for 1 cycle with 4 vectors in flight -> no out_valid afterwards; in_ready=0 until w_load.
